// File: rtl/distance_text_buffer_if.sv
// Bus between the distance readout overlay and its text buffer.
//   distance_in / distance_valid : binary distance sample and its one-cycle strobe
//   char_xy / char_code          : character-position read address and registered ASCII reply
//   busy / done                  : conversion status and commit pulse
interface distance_text_buffer_if;
  logic [15:0] distance_in;
  logic        distance_valid;
  logic [6:0]  char_xy;
  logic [6:0]  char_code;
  logic        busy;
  logic        done;

  modport master (
    output distance_in, distance_valid, char_xy,
    input  char_code, busy, done
  );

  modport slave (
    input  distance_in, distance_valid, char_xy,
    output char_code, busy, done
  );
endinterface

// File: rtl/distance_text_buffer.sv
// Distance readout text buffer: converts a 16-bit distance sample to decimal
// with a sequential double-dabble engine and serves a 4x16 ASCII page.
//   pclk   : pixel clock
//   rst_n  : asynchronous active-low reset
//   bus    : slave side of distance_text_buffer_if (sample in, char read, status)
// Digits d4..d0 sit at row 0 cols 6..10 and change only on a commit, so a
// frame never sees a half-converted value.
module distance_text_buffer #(
  parameter int unsigned MAX_CM = 400
) (
  input  logic                    pclk,
  input  logic                    rst_n,
  distance_text_buffer_if.slave   bus
);

  localparam int unsigned BIN_W = 16;
  localparam int unsigned BCD_W = 20;
  localparam int unsigned CHR_W = 7;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned NDIG  = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q;
  logic [BIN_W-1:0]            bin_q;
  logic [BCD_W-1:0]            bcd_q;
  logic                        over_q;
  logic                        pend_q, pend_d;
  logic [BIN_W-1:0]            pend_data_q, pend_data_d;
  logic                        load;
  logic [BIN_W-1:0]            load_val;
  logic                        busy_d;
  logic                        busy_q, done_q;
  logic [CHR_W-1:0]            code_q, code_d;
  logic [NDIG-1:0][CHR_W-1:0]  dig_q, dig_new;
  logic [BCD_W-1:0]            bcd_adj, bcd_shift;
  logic                        bcd_unused;
  logic                        xy_unused;
  logic                        leading;
  logic [3:0]                  nib;

  // State register
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state, sample loading and pending-slot control
  always_comb begin
    state_d     = state_q;
    load        = 1'b0;
    load_val    = bus.distance_in;
    pend_d      = pend_q;
    pend_data_d = pend_data_q;
    unique case (state_q)
      IDLE: begin
        if (bus.distance_valid) begin
          load    = 1'b1;
          state_d = CONV;
        end
      end
      CONV: begin
        if (bus.distance_valid) begin
          pend_d      = 1'b1;
          pend_data_d = bus.distance_in;
        end
        if (cnt_q == CNT_W'(15)) state_d = COMMIT;
      end
      COMMIT: begin
        // A strobe landing on the commit cycle is newer than any pending one
        if (bus.distance_valid || pend_q) begin
          load     = 1'b1;
          load_val = bus.distance_valid ? bus.distance_in : pend_data_q;
          pend_d   = 1'b0;
          state_d  = CONV;
        end else begin
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE) | pend_d;
  end

  // Double-dabble step: add 3 to nibbles >= 5, then shift in the binary MSB
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < int'(NDIG); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end
  assign {bcd_unused, bcd_shift} = {bcd_adj, bin_q[BIN_W-1]};

  // Final BCD to display characters with leading-zero blanking and over-range dashes
  always_comb begin
    dig_new = dig_q;
    leading = 1'b1;
    nib     = '0;
    for (int i = int'(NDIG) - 1; i >= 1; i--) begin
      nib = bcd_q[4*i +: 4];
      if (leading && (nib == 4'd0)) begin
        dig_new[i] = CHR_W'(8'h20);
      end else begin
        leading    = 1'b0;
        dig_new[i] = CHR_W'(8'h30) + CHR_W'(nib);
      end
    end
    dig_new[0] = CHR_W'(8'h30) + CHR_W'(bcd_q[3:0]);
    if (over_q) dig_new = {NDIG{CHR_W'(8'h2D)}};
  end

  // Conversion datapath, page digits and status outputs
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      bin_q       <= '0;
      bcd_q       <= '0;
      over_q      <= 1'b0;
      pend_q      <= 1'b0;
      pend_data_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dig_q       <= {CHR_W'(8'h20), CHR_W'(8'h20), CHR_W'(8'h20), CHR_W'(8'h20), CHR_W'(8'h30)};
    end else begin
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
      busy_q      <= busy_d;
      done_q      <= (state_q == COMMIT);
      if (state_q == COMMIT) dig_q <= dig_new;
      if (load) begin
        bin_q  <= load_val;
        bcd_q  <= '0;
        cnt_q  <= '0;
        over_q <= (load_val > BIN_W'(MAX_CM));
      end else if (state_q == CONV) begin
        bin_q <= {bin_q[BIN_W-2:0], 1'b0};
        bcd_q <= bcd_shift;
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Page lookup; address bit 6 is not decoded so it aliases the lower half
  assign xy_unused = bus.char_xy[6];
  always_comb begin
    code_d = CHR_W'(8'h20);
    if (bus.char_xy[5:4] == 2'd0) begin
      unique case (bus.char_xy[3:0])
        4'd0:    code_d = CHR_W'(8'h44);
        4'd1:    code_d = CHR_W'(8'h49);
        4'd2:    code_d = CHR_W'(8'h53);
        4'd3:    code_d = CHR_W'(8'h54);
        4'd4:    code_d = CHR_W'(8'h3A);
        4'd6:    code_d = dig_q[4];
        4'd7:    code_d = dig_q[3];
        4'd8:    code_d = dig_q[2];
        4'd9:    code_d = dig_q[1];
        4'd10:   code_d = dig_q[0];
        4'd12:   code_d = CHR_W'(8'h63);
        4'd13:   code_d = CHR_W'(8'h6D);
        default: code_d = CHR_W'(8'h20);
      endcase
    end
  end

  // Registered read port
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) code_q <= CHR_W'(8'h20);
    else        code_q <= code_d;
  end

  assign bus.char_code = code_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_distance_text_buffer.sv
// Self-checking bench for distance_text_buffer: randomized samples against a
// string-formatting reference of the displayed page plus timing checks.
module tb_distance_text_buffer;

  localparam int unsigned MAX_CM = 400;

  logic pclk = 1'b0;
  logic rst_n = 1'b0;
  always #5 pclk = ~pclk;

  distance_text_buffer_if bus();

  distance_text_buffer #(.MAX_CM(MAX_CM)) dut (
    .pclk  (pclk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;
  string disp    = "    0";

  // Expected 5-character digit field for a committed value
  function automatic string disp_of(input int unsigned v);
    if (v > MAX_CM) return "-----";
    return $sformatf("%5d", v);
  endfunction

  // Expected character at an address given the current digit field
  function automatic logic [6:0] exp_char(input logic [6:0] xy);
    string row0;
    row0 = {"DIST: ", disp, " cm  "};
    if (xy[5:4] != 2'd0) return 7'h20;
    return 7'(row0[int'(xy[3:0])]);
  endfunction

  task automatic tick();
    @(posedge pclk);
    #1;
    cyc++;
  endtask

  task automatic read_xy(input logic [6:0] xy, output logic [6:0] code);
    bus.char_xy = xy;
    tick();
    code = bus.char_code;
  endtask

  task automatic check_digits(input string tag);
    logic [6:0] code;
    for (int c = 6; c <= 10; c++) begin
      read_xy(7'(c), code);
      n_tests++;
      if (code !== exp_char(7'(c))) begin
        n_fail++;
        $display("FAIL %s digit col %0d: got 0x%02h expected 0x%02h", tag, c, code, exp_char(7'(c)));
      end
    end
  endtask

  task automatic convert(input logic [15:0] v, input string tag);
    int lat;
    bit seen;
    bus.distance_in    = v;
    bus.distance_valid = 1'b1;
    tick();
    bus.distance_valid = 1'b0;
    n_tests++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s busy after strobe: got %b expected 1", tag, bus.busy);
    end
    lat  = 1;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      tick();
      lat++;
      if (bus.done === 1'b1) seen = 1'b1;
    end
    n_tests++;
    if (!seen || lat != 18) begin
      n_fail++;
      $display("FAIL %s done latency: got %0d (seen=%0b) expected 18", tag, lat, seen);
    end
    disp = disp_of(int'(v));
    tick();
    n_tests++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s after pulse: done=%b busy=%b expected 0/0", tag, bus.done, bus.busy);
    end
    check_digits(tag);
  endtask

  task automatic test_reset();
    logic [6:0] code;
    logic [6:0] addrs [4];
    logic [6:0] exps  [4];
    addrs = '{7'h00, 7'h06, 7'h0A, 7'h0C};
    exps  = '{7'h44, 7'h20, 7'h30, 7'h63};
    rst_n = 1'b0;
    repeat (3) tick();
    n_tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.char_code !== 7'h20) begin
      n_fail++;
      $display("FAIL reset state: busy=%b done=%b code=0x%02h expected 0/0/0x20", bus.busy, bus.done, bus.char_code);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      read_xy(addrs[i], code);
      n_tests++;
      if (code !== exps[i]) begin
        n_fail++;
        $display("FAIL reset page xy 0x%02h: got 0x%02h expected 0x%02h", addrs[i], code, exps[i]);
      end
    end
    n_tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset idle: busy=%b done=%b expected 0/0", bus.busy, bus.done);
    end
  endtask

  task automatic test_directed();
    convert(16'd123, "d123");
    convert(16'd400, "d400");
    convert(16'd401, "d401");
    convert(16'd0, "d0");
    convert(16'd65535, "d65535");
    convert(16'd7, "d7");
  endtask

  task automatic test_random();
    logic [15:0] v;
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) v = 16'($urandom_range(0, 999));
      else            v = 16'($urandom);
      convert(v, $sformatf("rand%0d_%0d", i, v));
    end
  endtask

  task automatic test_back_to_back();
    int s;
    int t[$];
    bus.distance_in    = 16'd57;
    bus.distance_valid = 1'b1;
    tick();
    s = cyc;
    bus.distance_valid = 1'b0;
    repeat (3) tick();
    bus.distance_in    = 16'd88;
    bus.distance_valid = 1'b1;
    tick();
    bus.distance_valid = 1'b0;
    repeat (2) tick();
    bus.distance_in    = 16'd99;
    bus.distance_valid = 1'b1;
    tick();
    bus.distance_valid = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (bus.done === 1'b1) t.push_back(cyc);
      if (t.size() == 1) begin
        n_tests++;
        if (bus.busy !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b busy between pulses at cycle %0d: got %b expected 1", cyc - s, bus.busy);
        end
      end
    end
    n_tests++;
    if (t.size() != 2) begin
      n_fail++;
      $display("FAIL b2b pulse count: got %0d expected 2", t.size());
    end else begin
      n_tests++;
      if (t[0] - s != 17 || t[1] - t[0] != 17) begin
        n_fail++;
        $display("FAIL b2b spacing: first %0d gap %0d expected 17/17", t[0] - s, t[1] - t[0]);
      end
    end
    n_tests++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b final busy: got %b expected 0", bus.busy);
    end
    disp = disp_of(99);
    check_digits("b2b99");
  endtask

  task automatic test_commit_strobe();
    int s;
    int t2;
    bus.distance_in    = 16'd321;
    bus.distance_valid = 1'b1;
    tick();
    s = cyc;
    bus.distance_valid = 1'b0;
    repeat (16) tick();
    bus.distance_in    = 16'd77;
    bus.distance_valid = 1'b1;
    tick();
    bus.distance_valid = 1'b0;
    n_tests++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL commit-cycle strobe first commit: done=%b busy=%b expected 1/1", bus.done, bus.busy);
    end
    t2 = -1;
    for (int i = 0; i < 40 && t2 < 0; i++) begin
      tick();
      if (bus.done === 1'b1) t2 = cyc;
    end
    n_tests++;
    if (t2 - s != 34) begin
      n_fail++;
      $display("FAIL commit-cycle strobe second commit: got %0d expected 34", t2 - s);
    end
    disp = disp_of(77);
    tick();
    check_digits("commit77");
  endtask

  task automatic test_reset_mid();
    logic [6:0] code;
    bit done_seen;
    bus.distance_in    = 16'd250;
    bus.distance_valid = 1'b1;
    tick();
    bus.distance_valid = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.char_code !== 7'h20) begin
      n_fail++;
      $display("FAIL mid reset state: busy=%b done=%b code=0x%02h expected 0/0/0x20", bus.busy, bus.done, bus.char_code);
    end
    disp = "    0";
    tick();
    rst_n = 1'b1;
    read_xy(7'h0A, code);
    n_tests++;
    if (code !== 7'h30) begin
      n_fail++;
      $display("FAIL mid reset col10: got 0x%02h expected 0x30", code);
    end
    done_seen = 1'b0;
    repeat (30) begin
      tick();
      if (bus.done === 1'b1) done_seen = 1'b1;
    end
    n_tests++;
    if (done_seen || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid reset abandon: done_seen=%b busy=%b expected 0/0", done_seen, bus.busy);
    end
    check_digits("midreset");
  endtask

  task automatic test_page_static();
    logic [6:0] code;
    logic [6:0] xy;
    logic [6:0] fixed [4];
    fixed = '{7'h0E, 7'h0F, 7'h4A, 7'h40};
    for (int i = 0; i < 28; i++) begin
      if (i < 4)           xy = fixed[i];
      else if (i % 3 == 0) xy = {1'($urandom), 2'($urandom_range(1, 3)), 4'($urandom)};
      else                 xy = 7'($urandom);
      read_xy(xy, code);
      n_tests++;
      if (code !== exp_char(xy)) begin
        n_fail++;
        $display("FAIL page xy 0x%02h: got 0x%02h expected 0x%02h", xy, code, exp_char(xy));
      end
    end
  endtask

  initial begin
    bus.distance_in    = '0;
    bus.distance_valid = 1'b0;
    bus.char_xy        = '0;
    test_reset();
    test_directed();
    test_page_static();
    test_random();
    test_back_to_back();
    test_commit_strobe();
    test_reset_mid();
    test_page_static();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
